fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the pipelined CPU.
- Keeps its own shadow pipeline of destination tags for every stage from EX onward, up to DEPTH stages.
- Decodes the operands of the instruction in ID and registers per-operand forwarding selects into EX alignment.
- Raises stall for load-use hazards, with configurable load latency; supports global hold and flush.

Parameters:
- AW, 5: register address width.
- DEPTH, 3: number of result-carrying pipeline registers after EX (1=EX/MEM, 2=MEM/WB, 3=WB/extra).
- LOAD_LAT, 1: number of stages after EX in which a load result is not yet forwardable.
- CNTW, 16: width of the stall performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hold  in  1  global pipeline freeze (memory wait).
- flush  in  1  kill the instruction in ID.
- id_valid  in  1  ID slot holds a real instruction.
- id_rs, id_rt  in  AW  source register addresses.
- id_use_rs, id_use_rt  in  1  operand actually read.
- id_alu_imm  in  1  ALU B operand is the immediate; rt is still used as store data.
- id_we  in  1  instruction writes a register.
- id_rd  in  AW  resolved destination (RegDst already applied).
- id_is_load  in  1  instruction is a load.
- stall  out  1  combinational: hold IF/ID and insert a bubble into EX.
- ex_sel_a  out  SELW  registered select for ALU A.
- ex_sel_b  out  SELW  registered select for ALU B.
- ex_sel_st  out  SELW  registered select for store data.
- stall_cnt  out  CNTW  saturating count of stall cycles.

Behaviour:
- SELW = clog2(DEPTH+2).
- Select codes:
  - 0 = register file.
  - k in 1..DEPTH = pipeline register k.
  - DEPTH+1 = IMM, used only on ex_sel_b.
- Tag entries tag[0..DEPTH-1] each hold {v, we, rd, ld}; tag[0] is the instruction now in EX.
- Normal clock edge (hold=0):
  - tag[j+1] <= tag[j]; the oldest tag is dropped.
  - tag[0] <= ID instruction if id_valid & !flush & !stall, else bubble (v=0).
- Match at tag[j] for source s: v & we & rd!=0 & rd==s & the operand's use flag is set.
  - The youngest match (smallest j) wins.
  - The next-cycle select is j+1.
  - No match gives 0. j+1 > DEPTH cannot occur because the array is DEPTH deep.
- Load-use: a match with ld=1 and j+1 <= LOAD_LAT asserts stall (id_valid=1, flush=0).
- Stall is the OR over both operands.
- Output registers load on every non-hold edge:
  - Instruction entering EX: computed selects.
  - Bubble entering EX: all selects 0.
- ex_sel_b = IMM when id_alu_imm=1, regardless of rt match; ex_sel_st still carries the rt match.
- ex_sel_b = rt select when id_alu_imm=0, and ex_sel_st equals it.
- hold=1: tags, outputs and stall_cnt are frozen; stall is still evaluated combinationally.
- flush=1: stall forced 0 and a bubble enters EX. Flush takes priority over stall; hold takes priority over both.
- stall_cnt increments on each non-hold edge with stall=1 and saturates at all-ones.
- Reset (asynchronous, rst_n=0):
  - All tags invalid; ex_sel_* = 0; stall_cnt = 0.
  - stall = 0 immediately, because no valid tags remain.
  - Reset mid-stall drops the pending hazard.

Decomposition:
- Package fwd_pkg holds:
  - The tag typedef {v, we, rd[AW], ld}.
  - Constants SEL_RF=0 and the SELW/SEL_IMM derivation.
- One sub-module, fwd_tag_pipe: the DEPTH-entry tag shift register with hold, bubble insert and async reset.
- Match/priority logic and the output registers stay in the top module.

Test Plan (DEPTH=3, LOAD_LAT=1):
1. Dependency distance:
   - add r3 issued, then the next ID reads rs=3 -> next cycle ex_sel_a=1.
   - Distance 2 -> 2; distance 3 -> 3; distance 4 -> 0.
2. r5 written by tag[0] and tag[1], ID reads rt=5 with id_alu_imm=0 -> ex_sel_b=1 and ex_sel_st=1 (youngest wins).
3. lw r4 then add rs=4:
   - stall=1 for exactly 1 cycle, and EX shows a bubble with all selects 0.
   - Next cycle ex_sel_a=2 and stall_cnt=1.
4. Write to r0, consumer reads r0 -> all selects 0, no stall.
5. Store-type instruction with id_alu_imm=1 and rt=3 matching tag[0] -> ex_sel_b=4 (IMM), ex_sel_st=1.
6. Hold and reset:
   - hold=1 for 2 cycles during a load-use stall -> outputs and stall_cnt unchanged, stall stays 1.
   - rst_n low mid-stall -> stall=0 and outputs 0 before the next edge.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and select-code helpers for the forwarding/hazard unit.
// Tags carry a fixed-width rd so the package stays parameter-free; AW must not exceed AW_MAX.
package fwd_pkg;

    localparam int unsigned AW_MAX = 16;
    localparam int unsigned SEL_RF = 0;

    typedef struct packed {
        logic              v;
        logic              we;
        logic [AW_MAX-1:0] rd;
        logic              ld;
    } tag_t;

    function automatic int unsigned sel_w(input int unsigned depth);
        return $clog2(depth + 2);
    endfunction

    function automatic int unsigned sel_imm(input int unsigned depth);
        return depth + 1;
    endfunction

endpackage

// File: rtl/fwd_tag_pipe.sv
// Shadow pipeline of destination tags; tags[0] is the instruction in EX.
module fwd_tag_pipe
    import fwd_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    input  logic push,
    input  tag_t din,
    output tag_t tags [DEPTH]
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                tags[j] <= '0;
            end
        end else if (!hold) begin
            tags[0] <= push ? din : '0;
            for (int unsigned j = 1; j < DEPTH; j++) begin
                tags[j] <= tags[j-1];
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select generation and load-use stall detection.
// Selects are registered into EX alignment; stall is combinational from ID and the tag pipe.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter  int unsigned AW       = 5,
    parameter  int unsigned DEPTH    = 3,
    parameter  int unsigned LOAD_LAT = 1,
    parameter  int unsigned CNTW     = 16,
    localparam int unsigned SELW     = sel_w(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hold,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic            id_alu_imm,
    input  logic            id_we,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_is_load,
    output logic            stall,
    output logic [SELW-1:0] ex_sel_a,
    output logic [SELW-1:0] ex_sel_b,
    output logic [SELW-1:0] ex_sel_st,
    output logic [CNTW-1:0] stall_cnt
);

    localparam logic [SELW-1:0] SEL_IMM_C = SELW'(sel_imm(DEPTH));
    localparam logic [SELW-1:0] SEL_RF_C  = SELW'(SEL_RF);

    tag_t            tags [DEPTH];
    tag_t            id_tag;
    logic            enter;
    logic [SELW-1:0] rs_sel, rt_sel;
    logic            rs_haz, rt_haz;

    function automatic logic hit(input tag_t t, input logic [AW-1:0] s);
        return t.v && t.we && (t.rd != '0) && (t.rd == AW_MAX'(s));
    endfunction

    always_comb begin
        id_tag    = '0;
        id_tag.v  = 1'b1;
        id_tag.we = id_we;
        id_tag.rd = AW_MAX'(id_rd);
        id_tag.ld = id_is_load;
    end

    // Scan oldest to youngest so the youngest match overwrites both select and hazard flag.
    always_comb begin
        rs_sel = SEL_RF_C;
        rt_sel = SEL_RF_C;
        rs_haz = 1'b0;
        rt_haz = 1'b0;
        for (int unsigned j = DEPTH; j > 0; j--) begin
            if (id_use_rs && hit(tags[j-1], id_rs)) begin
                rs_sel = SELW'(j);
                rs_haz = tags[j-1].ld && (j <= LOAD_LAT);
            end
            if (id_use_rt && hit(tags[j-1], id_rt)) begin
                rt_sel = SELW'(j);
                rt_haz = tags[j-1].ld && (j <= LOAD_LAT);
            end
        end
    end

    assign stall = id_valid && !flush && (rs_haz || rt_haz);
    assign enter = id_valid && !flush && !stall;

    fwd_tag_pipe #(
        .DEPTH (DEPTH)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (hold),
        .push  (enter),
        .din   (id_tag),
        .tags  (tags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_sel_a  <= '0;
            ex_sel_b  <= '0;
            ex_sel_st <= '0;
            stall_cnt <= '0;
        end else if (!hold) begin
            if (enter) begin
                ex_sel_a  <= rs_sel;
                ex_sel_b  <= id_alu_imm ? SEL_IMM_C : rt_sel;
                ex_sel_st <= rt_sel;
            end else begin
                ex_sel_a  <= '0;
                ex_sel_b  <= '0;
                ex_sel_st <= '0;
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed scoreboard bench for fwd_hazard_unit (DEPTH=3, LOAD_LAT=1, narrow counter).
module tb_fwd_hazard_unit;

    localparam int unsigned AW   = 5;
    localparam int unsigned SELW = 3;
    localparam int unsigned CNTW = 4;

    logic            clk, rst_n, hold, flush;
    logic            id_valid, id_use_rs, id_use_rt, id_alu_imm, id_we, id_is_load;
    logic [AW-1:0]   id_rs, id_rt, id_rd;
    logic            stall;
    logic [SELW-1:0] ex_sel_a, ex_sel_b, ex_sel_st;
    logic [CNTW-1:0] stall_cnt;

    logic [3*SELW-1:0] sb [$];
    logic [3*SELW-1:0] exp_sel, got_sel;
    logic [CNTW-1:0]   exp_cnt;
    int                vectors, miscompares;

    fwd_hazard_unit #(
        .AW       (AW),
        .DEPTH    (3),
        .LOAD_LAT (1),
        .CNTW     (CNTW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (hold),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .id_alu_imm (id_alu_imm),
        .id_we      (id_we),
        .id_rd      (id_rd),
        .id_is_load (id_is_load),
        .stall      (stall),
        .ex_sel_a   (ex_sel_a),
        .ex_sel_b   (ex_sel_b),
        .ex_sel_st  (ex_sel_st),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic urs,
                          input logic [AW-1:0] rt, input logic urt, input logic imm,
                          input logic we, input logic [AW-1:0] rd, input logic ld);
        id_valid = v;  id_rs = rs;  id_use_rs = urs;  id_rt = rt;  id_use_rt = urt;
        id_alu_imm = imm;  id_we = we;  id_rd = rd;  id_is_load = ld;
    endtask

    task automatic issue_wr(input logic [AW-1:0] rd, input logic ld);
        set_id(1, 0, 0, 0, 0, 0, 1, rd, ld);
        tick();
    endtask

    task automatic issue_nop();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) tick();
    endtask

    task automatic test_reset();
        vectors++;
        if ({stall, ex_sel_a, ex_sel_b, ex_sel_st, stall_cnt} !== '0) begin
            miscompares++;
            $display("FAIL reset_state got stall=%b a=%0d b=%0d st=%0d cnt=%0d exp all 0",
                     stall, ex_sel_a, ex_sel_b, ex_sel_st, stall_cnt);
        end
    endtask

    task automatic test_distance();
        logic [SELW-1:0] want [4];
        want[0] = 1; want[1] = 2; want[2] = 3; want[3] = 0;
        for (int d = 1; d <= 4; d++) begin
            drain();
            issue_wr(3, 0);
            for (int n = 1; n < d; n++) issue_nop();
            set_id(1, 3, 1, 0, 0, 0, 0, 0, 0);
            sb.push_back({want[d-1], 3'd0, 3'd0});
            tick();
            got_sel = {ex_sel_a, ex_sel_b, ex_sel_st};
            exp_sel = sb.pop_front();
            vectors++;
            if (got_sel !== exp_sel) begin
                miscompares++;
                $display("FAIL distance_%0d got {a,b,st}=%h exp=%h", d, got_sel, exp_sel);
            end
        end
    endtask

    task automatic test_youngest();
        drain();
        issue_wr(5, 0);
        issue_wr(5, 0);
        set_id(1, 0, 0, 5, 1, 0, 0, 0, 0);
        sb.push_back({3'd0, 3'd1, 3'd1});
        tick();
        got_sel = {ex_sel_a, ex_sel_b, ex_sel_st};
        exp_sel = sb.pop_front();
        vectors++;
        if (got_sel !== exp_sel) begin
            miscompares++;
            $display("FAIL youngest_wins got {a,b,st}=%h exp=%h", got_sel, exp_sel);
        end
    endtask

    task automatic test_load_use();
        drain();
        issue_wr(4, 1);
        set_id(1, 4, 1, 0, 0, 0, 0, 0, 0);
        #1;
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL load_use_stall got=%b exp=1", stall);
        end
        sb.push_back('0);
        tick();
        exp_cnt = exp_cnt + 1;
        got_sel = {ex_sel_a, ex_sel_b, ex_sel_st};
        exp_sel = sb.pop_front();
        vectors++;
        if (got_sel !== exp_sel || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL load_use_bubble got sel=%h stall=%b exp sel=%h stall=0",
                     got_sel, stall, exp_sel);
        end
        sb.push_back({3'd2, 3'd0, 3'd0});
        tick();
        got_sel = {ex_sel_a, ex_sel_b, ex_sel_st};
        exp_sel = sb.pop_front();
        vectors++;
        if (got_sel !== exp_sel || stall_cnt !== exp_cnt) begin
            miscompares++;
            $display("FAIL load_use_fwd got sel=%h cnt=%0d exp sel=%h cnt=%0d",
                     got_sel, stall_cnt, exp_sel, exp_cnt);
        end
    endtask

    task automatic test_flush();
        drain();
        issue_wr(4, 1);
        set_id(1, 4, 1, 0, 0, 0, 0, 0, 0);
        flush = 1'b1;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_no_stall got=%b exp=0", stall);
        end
        sb.push_back('0);
        tick();
        flush = 1'b0;
        got_sel = {ex_sel_a, ex_sel_b, ex_sel_st};
        exp_sel = sb.pop_front();
        vectors++;
        if (got_sel !== exp_sel || stall_cnt !== exp_cnt) begin
            miscompares++;
            $display("FAIL flush_bubble got sel=%h cnt=%0d exp sel=%h cnt=%0d",
                     got_sel, stall_cnt, exp_sel, exp_cnt);
        end
    endtask

    task automatic test_r0();
        drain();
        issue_wr(0, 1);
        set_id(1, 0, 1, 0, 1, 0, 0, 0, 0);
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL r0_stall got=%b exp=0", stall);
        end
        sb.push_back('0);
        tick();
        got_sel = {ex_sel_a, ex_sel_b, ex_sel_st};
        exp_sel = sb.pop_front();
        vectors++;
        if (got_sel !== exp_sel) begin
            miscompares++;
            $display("FAIL r0_sel got {a,b,st}=%h exp=%h", got_sel, exp_sel);
        end
    endtask

    task automatic test_imm_store();
        drain();
        issue_wr(3, 0);
        set_id(1, 0, 0, 3, 1, 1, 0, 0, 0);
        sb.push_back({3'd0, 3'd4, 3'd1});
        tick();
        got_sel = {ex_sel_a, ex_sel_b, ex_sel_st};
        exp_sel = sb.pop_front();
        vectors++;
        if (got_sel !== exp_sel) begin
            miscompares++;
            $display("FAIL imm_store got {a,b,st}=%h exp=%h", got_sel, exp_sel);
        end
    endtask

    task automatic test_hold_reset();
        drain();
        issue_wr(3, 0);
        set_id(1, 3, 1, 0, 0, 0, 1, 7, 1);
        tick();
        set_id(1, 7, 1, 0, 0, 0, 0, 0, 0);
        hold = 1'b1;
        for (int c = 0; c < 2; c++) begin
            sb.push_back({3'd1, 3'd0, 3'd0});
            tick();
            got_sel = {ex_sel_a, ex_sel_b, ex_sel_st};
            exp_sel = sb.pop_front();
            vectors++;
            if (got_sel !== exp_sel || stall_cnt !== exp_cnt || stall !== 1'b1) begin
                miscompares++;
                $display("FAIL hold_%0d got sel=%h cnt=%0d stall=%b exp sel=%h cnt=%0d stall=1",
                         c, got_sel, stall_cnt, stall, exp_sel, exp_cnt);
            end
        end
        hold = 1'b0;
        rst_n = 1'b0;
        exp_cnt = '0;
        #1;
        vectors++;
        if ({stall, ex_sel_a, ex_sel_b, ex_sel_st, stall_cnt} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_stall got stall=%b a=%0d b=%0d st=%0d cnt=%0d exp all 0",
                     stall, ex_sel_a, ex_sel_b, ex_sel_st, stall_cnt);
        end
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        drain();
        for (int i = 0; i < 17; i++) begin
            issue_wr(4, 1);
            set_id(1, 4, 1, 0, 0, 0, 0, 0, 0);
            tick();
            tick();
        end
        exp_cnt = 4'hF;
        vectors++;
        if (stall_cnt !== exp_cnt) begin
            miscompares++;
            $display("FAIL cnt_saturate got=%0d exp=%0d", stall_cnt, exp_cnt);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        exp_cnt = '0;
        rst_n = 1'b0;
        hold = 1'b0;
        flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        test_reset();
        #9;
        rst_n = 1'b1;
        tick();
        test_reset();
        test_distance();
        test_youngest();
        test_load_use();
        test_flush();
        test_r0();
        test_imm_store();
        test_hold_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
